mem_stage_wait: RTL and testbench
=================================

Name: mem_stage_wait

Overview:
- Parametrised MEM pipeline stage. It combines three things:
  - the EX/MEM pipeline register;
  - a word-organised data memory with MIPS sub-word loads and stores;
  - a wait-state controller with a configurable access latency.
- It sits between the EX stage and the MEM/WB register.
- It adds behaviour the earlier fixed-word, zero-latency MEM path lacks: byte/halfword access, misalignment detection, and a STALL output to freeze upstream stages.

Parameters:
- ADDR_WIDTH, 8, word-address bits; memory holds 2**ADDR_WIDTH 32-bit words.
- LATENCY, 0, extra wait cycles per load/store (legal range 0..15).
- CNT_WIDTH, 4, width of the wait counter; must hold LATENCY.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- EX_RegWrite  in  1  WB control from EX.
- EX_MemtoReg  in  1  WB control from EX.
- EX_MemRead  in  1  load request.
- EX_MemWrite  in  1  store request.
- EX_Opcode  in  6  instruction opcode; selects the access size.
- EX_ALU_RESULT  in  32  byte address, or ALU result.
- EX_RT_DATA  in  32  store data.
- EX_RD  in  5  destination register.
- MEM_RegWrite  out  1  registered control.
- MEM_MemtoReg  out  1  registered control.
- MEM_ALU_RESULT  out  32  registered address/result.
- MEM_RD  out  5  registered destination.
- MEM_Opcode  out  6  registered opcode.
- Read_data  out  32  extended load result; valid when STALL=0.
- STALL  out  1  combinational; upstream and EX/MEM must hold while 1.
- MISALIGN  out  1  combinational; the current MEM instruction is misaligned.

Behaviour:
- Reset: all MEM_* outputs are 0 (bubble). Wait counter = 0. All memory words = 0. STALL=0, MISALIGN=0, Read_data=0.
- Opcodes and access types:
  - Loads: lb 100000, lh 100001, lw 100011, lbu 100100, lhu 100101.
  - Stores: sb 101000, sh 101001, sw 101011.
  - A MemRead/MemWrite with any other opcode is treated as lw/sw.
- Addressing:
  - Word index = MEM_ALU_RESULT[ADDR_WIDTH+1:2]; upper address bits are ignored, so addresses wrap.
  - Big-endian: byte offset 0 is bits 31:24. Halfword offset 0 is bits 31:16.
- Misalignment:
  - MISALIGN=1 when a halfword access has addr[0]=1, or a word access has addr[1:0]!=0.
  - A misaligned access does no memory write, gives Read_data=0, and causes no stall.
- Load extension: lb/lh sign-extend; lbu/lhu zero-extend.
- Read_data is 0 when MemRead=0.
- Memory read is combinational from the array.
- Wait control:
  - mem_op = (MEM_MemRead | MEM_MemWrite) & ~MISALIGN.
  - STALL = mem_op & (cnt != LATENCY).
- Each edge:
  - If STALL=1: cnt increments; the EX/MEM register holds; no write.
  - If STALL=0: the EX/MEM register loads the EX_* inputs and cnt clears to 0. A pending aligned store commits on this same edge, writing only its byte lanes.
- An access therefore occupies LATENCY+1 cycles. With LATENCY=0 it behaves as a single-cycle MEM stage.
- Stores: sb writes one lane, sh two lanes, sw all four. Store data comes from the low bits of RT_DATA, placed into the lane(s) selected by the address offset.
- Back-to-back accesses: each new access restarts the counter. A load immediately after a store to the same word sees the updated data.
- Reset during a stall: the pending store is discarded, and STALL is 0 from the next cycle.
- A bubble (all controls 0) never stalls.

Decomposition:
- Shared package mips_mem_pkg holds the opcode constants above, plus an access-size enumeration (BYTE, HALF, WORD) and a signed/unsigned flag.
- One natural sub-module: mem_lane_align. It is purely combinational:
  - input: opcode, address offset, read word and store data;
  - output: byte-enable mask, aligned write word, extended load data, misalign flag.
- The FSM, counter, register and memory array remain in mem_stage_wait.

Test Plan:
- LATENCY=0 baseline: sw addr 8 data 50, then lw addr 8 -> Read_data=50; STALL never asserted.
- Sub-word, big-endian: sw addr 4 data 0x80FF1234; then
  - lb addr 4 -> 0xFFFFFF80;
  - lbu addr 5 -> 0x000000FF;
  - lh addr 6 -> 0x00001234;
  - sb addr 7 data 0xAA, then lw addr 4 -> 0x80FF12AA.
- LATENCY=3: a lw holds STALL=1 for exactly 3 cycles. MEM_* outputs stay constant during the stall, and upstream changes are ignored. The next instruction is latched on the 4th edge.
- Misalignment: lw addr 6 -> MISALIGN=1, Read_data=0, no stall. sh addr 3 data 0x1 -> memory unchanged. addi (controls 0) addr 20 -> no stall, MISALIGN=0.
- Wrap and reset: with ADDR_WIDTH=8, sw addr 0x400 data 7, then lw addr 0 -> 7. RESET asserted during a LATENCY=3 sw stall -> no write, all outputs 0 next cycle, and a subsequent lw returns 0.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared MEM-stage definitions: MIPS load/store opcodes, access size and
// load-extension mode, plus decode helpers used by the lane aligner.
package mips_mem_pkg;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } acc_size_e;

    typedef enum logic {
        EXT_ZERO = 1'b0,
        EXT_SIGN = 1'b1
    } ext_mode_e;

    // Unknown opcodes fall back to a full-word access.
    function automatic acc_size_e op_size(input logic [5:0] op);
        acc_size_e size;
        case (op)
            OP_LB, OP_LBU, OP_SB: size = SIZE_BYTE;
            OP_LH, OP_LHU, OP_SH: size = SIZE_HALF;
            default:              size = SIZE_WORD;
        endcase
        return size;
    endfunction

    // Only the explicitly unsigned loads zero-extend.
    function automatic ext_mode_e op_ext(input logic [5:0] op);
        ext_mode_e ext;
        case (op)
            OP_LBU, OP_LHU: ext = EXT_ZERO;
            default:        ext = EXT_SIGN;
        endcase
        return ext;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational big-endian lane steering: byte enables and replicated store
// data for writes, lane selection and extension for loads, and the
// alignment check for halfword/word accesses.
module mem_lane_align
    import mips_mem_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [1:0]  offset,
    input  logic [31:0] rd_word,
    input  logic [31:0] st_data,
    output logic [3:0]  byte_en,
    output logic [31:0] wr_word,
    output logic [31:0] ld_data,
    output logic        misalign
);

    acc_size_e   size_s;
    ext_mode_e   ext_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed byte/halfword (offset 0 is the most significant lane).
    always_comb begin
        size_s = op_size(opcode);
        ext_s  = op_ext(opcode);
        case (offset)
            2'd0:    byte_s = rd_word[31:24];
            2'd1:    byte_s = rd_word[23:16];
            2'd2:    byte_s = rd_word[15:8];
            2'd3:    byte_s = rd_word[7:0];
            default: byte_s = 8'h00;
        endcase
        if (offset[1]) begin
            half_s = rd_word[15:0];
        end else begin
            half_s = rd_word[31:16];
        end
    end

    // Build enables, write data, extended load data and the misalign flag.
    always_comb begin
        byte_en  = 4'b0000;
        wr_word  = 32'h0000_0000;
        ld_data  = 32'h0000_0000;
        misalign = 1'b0;
        case (size_s)
            SIZE_BYTE: begin
                byte_en = 4'b1000 >> offset;
                wr_word = {4{st_data[7:0]}};
                if (ext_s == EXT_SIGN) begin
                    ld_data = {{24{byte_s[7]}}, byte_s};
                end else begin
                    ld_data = {24'h00_0000, byte_s};
                end
                misalign = 1'b0;
            end
            SIZE_HALF: begin
                if (offset[1]) begin
                    byte_en = 4'b0011;
                end else begin
                    byte_en = 4'b1100;
                end
                wr_word = {2{st_data[15:0]}};
                if (ext_s == EXT_SIGN) begin
                    ld_data = {{16{half_s[15]}}, half_s};
                end else begin
                    ld_data = {16'h0000, half_s};
                end
                misalign = offset[0];
            end
            default: begin
                byte_en  = 4'b1111;
                wr_word  = st_data;
                ld_data  = rd_word;
                misalign = (offset != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_stage_wait.sv
// MEM pipeline stage: EX/MEM register, word-organised data memory with
// sub-word access, and a wait-state counter that stalls upstream for
// LATENCY extra cycles on every aligned load or store.
module mem_stage_wait
    import mips_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 0,
    parameter int CNT_WIDTH  = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        EX_RegWrite,
    input  logic        EX_MemtoReg,
    input  logic        EX_MemRead,
    input  logic        EX_MemWrite,
    input  logic [5:0]  EX_Opcode,
    input  logic [31:0] EX_ALU_RESULT,
    input  logic [31:0] EX_RT_DATA,
    input  logic [4:0]  EX_RD,
    output logic        MEM_RegWrite,
    output logic        MEM_MemtoReg,
    output logic [31:0] MEM_ALU_RESULT,
    output logic [4:0]  MEM_RD,
    output logic [5:0]  MEM_Opcode,
    output logic [31:0] Read_data,
    output logic        STALL,
    output logic        MISALIGN
);

    localparam int                   DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] LAT_C = CNT_WIDTH'(LATENCY);

    logic                  regwrite_r;
    logic                  memtoreg_r;
    logic                  memread_r;
    logic                  memwrite_r;
    logic [5:0]            opcode_r;
    logic [31:0]           alu_r;
    logic [31:0]           rt_data_r;
    logic [4:0]            rd_r;
    logic [CNT_WIDTH-1:0]  cnt_r;
    logic [31:0]           mem_r [DEPTH];

    logic [ADDR_WIDTH-1:0] word_idx_s;
    logic [31:0]           rd_word_s;
    logic [3:0]            byte_en_s;
    logic [31:0]           wr_word_s;
    logic [31:0]           ld_data_s;
    logic                  lane_mis_s;
    logic                  access_s;
    logic                  mem_op_s;
    logic                  stall_s;
    logic [31:0]           lane_mask_s;
    logic [31:0]           read_data_s;

    assign word_idx_s  = alu_r[ADDR_WIDTH+1:2];
    assign rd_word_s   = mem_r[word_idx_s];
    assign access_s    = memread_r | memwrite_r;
    assign mem_op_s    = access_s & ~lane_mis_s;
    assign stall_s     = mem_op_s & (cnt_r != LAT_C);
    assign lane_mask_s = {{8{byte_en_s[3]}}, {8{byte_en_s[2]}},
                          {8{byte_en_s[1]}}, {8{byte_en_s[0]}}};

    mem_lane_align u_lane_align (
        .opcode   (opcode_r),
        .offset   (alu_r[1:0]),
        .rd_word  (rd_word_s),
        .st_data  (rt_data_r),
        .byte_en  (byte_en_s),
        .wr_word  (wr_word_s),
        .ld_data  (ld_data_s),
        .misalign (lane_mis_s)
    );

    // Load result is only driven for an aligned load; otherwise zero.
    always_comb begin
        read_data_s = 32'h0000_0000;
        if (memread_r && !lane_mis_s) begin
            read_data_s = ld_data_s;
        end else begin
            read_data_s = 32'h0000_0000;
        end
    end

    // EX/MEM register: loads from EX unless the current access is waiting.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            regwrite_r <= 1'b0;
            memtoreg_r <= 1'b0;
            memread_r  <= 1'b0;
            memwrite_r <= 1'b0;
            opcode_r   <= 6'd0;
            alu_r      <= 32'h0000_0000;
            rt_data_r  <= 32'h0000_0000;
            rd_r       <= 5'd0;
        end else if (!stall_s) begin
            regwrite_r <= EX_RegWrite;
            memtoreg_r <= EX_MemtoReg;
            memread_r  <= EX_MemRead;
            memwrite_r <= EX_MemWrite;
            opcode_r   <= EX_Opcode;
            alu_r      <= EX_ALU_RESULT;
            rt_data_r  <= EX_RT_DATA;
            rd_r       <= EX_RD;
        end else begin
            regwrite_r <= regwrite_r;
            memtoreg_r <= memtoreg_r;
            memread_r  <= memread_r;
            memwrite_r <= memwrite_r;
            opcode_r   <= opcode_r;
            alu_r      <= alu_r;
            rt_data_r  <= rt_data_r;
            rd_r       <= rd_r;
        end
    end

    // Wait counter: counts stall cycles, restarts whenever the stage advances.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_r <= '0;
        end else if (stall_s) begin
            cnt_r <= cnt_r + CNT_WIDTH'(1);
        end else begin
            cnt_r <= '0;
        end
    end

    // Data memory: an aligned store commits its lanes on the edge it retires.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
        end else if (!stall_s && memwrite_r && !lane_mis_s) begin
            mem_r[word_idx_s] <= (rd_word_s & ~lane_mask_s) | (wr_word_s & lane_mask_s);
        end else begin
            mem_r[word_idx_s] <= rd_word_s;
        end
    end

    assign MEM_RegWrite   = regwrite_r;
    assign MEM_MemtoReg   = memtoreg_r;
    assign MEM_ALU_RESULT = alu_r;
    assign MEM_RD         = rd_r;
    assign MEM_Opcode     = opcode_r;
    assign Read_data      = read_data_s;
    assign STALL          = stall_s;
    assign MISALIGN       = access_s & lane_mis_s;

endmodule

// File: tb/tb_mem_stage_wait.sv
// Bench for mem_stage_wait: one zero-latency and one three-wait-state
// instance, each fed instructions with expected results queued at drive time.
module tb_mem_stage_wait;

    typedef struct packed {
        logic        regwrite;
        logic        memtoreg;
        logic        memread;
        logic        memwrite;
        logic [5:0]  opcode;
        logic [31:0] alu;
        logic [31:0] rt;
        logic [4:0]  rd;
    } instr_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        mis;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic [7:0]  ctl;
    } exp_t;

    logic   CLK;
    logic   rst0, rst3;
    instr_t in0, in3;
    exp_t   sb_q[$];
    int     total = 0;
    int     bad   = 0;

    logic        regwrite0, memtoreg0, stall0, mis0;
    logic [31:0] alu0, rdata0;
    logic [4:0]  rd0;
    logic [5:0]  op0;
    logic        regwrite3, memtoreg3, stall3, mis3;
    logic [31:0] alu3, rdata3;
    logic [4:0]  rd3;
    logic [5:0]  op3;

    mem_stage_wait #(.ADDR_WIDTH(8), .LATENCY(0), .CNT_WIDTH(4)) u_dut0 (
        .CLK(CLK), .RESET(rst0),
        .EX_RegWrite(in0.regwrite), .EX_MemtoReg(in0.memtoreg),
        .EX_MemRead(in0.memread), .EX_MemWrite(in0.memwrite),
        .EX_Opcode(in0.opcode), .EX_ALU_RESULT(in0.alu),
        .EX_RT_DATA(in0.rt), .EX_RD(in0.rd),
        .MEM_RegWrite(regwrite0), .MEM_MemtoReg(memtoreg0),
        .MEM_ALU_RESULT(alu0), .MEM_RD(rd0), .MEM_Opcode(op0),
        .Read_data(rdata0), .STALL(stall0), .MISALIGN(mis0)
    );

    mem_stage_wait #(.ADDR_WIDTH(8), .LATENCY(3), .CNT_WIDTH(4)) u_dut3 (
        .CLK(CLK), .RESET(rst3),
        .EX_RegWrite(in3.regwrite), .EX_MemtoReg(in3.memtoreg),
        .EX_MemRead(in3.memread), .EX_MemWrite(in3.memwrite),
        .EX_Opcode(in3.opcode), .EX_ALU_RESULT(in3.alu),
        .EX_RT_DATA(in3.rt), .EX_RD(in3.rd),
        .MEM_RegWrite(regwrite3), .MEM_MemtoReg(memtoreg3),
        .MEM_ALU_RESULT(alu3), .MEM_RD(rd3), .MEM_Opcode(op3),
        .Read_data(rdata3), .STALL(stall3), .MISALIGN(mis3)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Hard stop in case anything wedges.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    function automatic instr_t mk(input logic rd_f, input logic wr_f, input logic [5:0] op,
                                  input logic [31:0] a, input logic [31:0] d, input logic [4:0] r);
        instr_t i;
        i.regwrite = rd_f | (~rd_f & ~wr_f);
        i.memtoreg = rd_f;
        i.memread  = rd_f;
        i.memwrite = wr_f;
        i.opcode   = op;
        i.alu      = a;
        i.rt       = d;
        i.rd       = r;
        return i;
    endfunction

    function automatic exp_t mk_exp(input instr_t i, input logic [31:0] rdata, input logic mis);
        exp_t e;
        e.rdata = rdata;
        e.mis   = mis;
        e.alu   = i.alu;
        e.rd    = i.rd;
        e.ctl   = {i.regwrite, i.memtoreg, i.opcode};
        return e;
    endfunction

    // Zero-latency instance: the instruction retires one edge after it is driven.
    task automatic run0(input instr_t i, input logic [31:0] exp_rd, input logic exp_mis);
        exp_t e;
        @(negedge CLK);
        in0 = i;
        sb_q.push_back(mk_exp(i, exp_rd, exp_mis));
        @(posedge CLK);
        #1;
        e = sb_q.pop_front();
        chk_val("l0_rdata", rdata0, e.rdata);
        chk_val("l0_misalign", 32'(mis0), 32'(e.mis));
        chk_val("l0_stall", 32'(stall0), 32'd0);
        chk_val("l0_alu", alu0, e.alu);
        chk_val("l0_rd_ctl", {19'd0, rd0, regwrite0, memtoreg0, op0}, {19'd0, e.rd, e.ctl});
    endtask

    // Three-wait instance: counts stall cycles while scrambling the EX inputs.
    task automatic run3(input instr_t i, input logic [31:0] exp_rd, input int exp_stalls);
        exp_t e;
        int   n;
        @(negedge CLK);
        in3 = i;
        sb_q.push_back(mk_exp(i, exp_rd, 1'b0));
        @(posedge CLK);
        #1;
        in3 = mk(1'b1, 1'b1, 6'b101011, 32'h0000_DEAC, 32'hDEAD_BEEF, 5'd31);
        n = 0;
        while (stall3 && n < 20) begin
            chk_val("l3_hold_alu", alu3, i.alu);
            n++;
            @(posedge CLK);
            #1;
        end
        if (n >= 20) begin
            chk_val("l3_stall_timeout", 32'(n), 32'(exp_stalls));
        end
        chk_val("l3_stall_cycles", 32'(n), 32'(exp_stalls));
        e = sb_q.pop_front();
        chk_val("l3_rdata", rdata3, e.rdata);
        chk_val("l3_alu", alu3, e.alu);
        chk_val("l3_rd_ctl", {19'd0, rd3, regwrite3, memtoreg3, op3}, {19'd0, e.rd, e.ctl});
        @(negedge CLK);
        in3 = '0;
    endtask

    task automatic chk_zero3(input string tag);
        chk_val({tag, "_alu"}, alu3, 32'd0);
        chk_val({tag, "_ctl"}, {19'd0, rd3, regwrite3, memtoreg3, op3}, 32'd0);
        chk_val({tag, "_rdata"}, rdata3, 32'd0);
        chk_val({tag, "_stall_mis"}, {30'd0, stall3, mis3}, 32'd0);
    endtask

    initial begin
        rst0 = 1'b1;
        rst3 = 1'b1;
        in0  = '0;
        in3  = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk_val("rst0_outs", {alu0 ^ rdata0}, 32'd0);
        chk_val("rst0_ctl", {17'd0, rd0, regwrite0, memtoreg0, op0, stall0, mis0}, 32'd0);
        chk_zero3("rst3");
        @(negedge CLK);
        rst0 = 1'b0;
        rst3 = 1'b0;

        // Zero-latency baseline, sub-word big-endian, misalignment, wrap.
        run0(mk(1'b0, 1'b1, 6'b101011, 32'd8, 32'd50, 5'd0), 32'd0, 1'b0);
        run0(mk(1'b1, 1'b0, 6'b100011, 32'd8, 32'd0, 5'd2), 32'd50, 1'b0);
        run0(mk(1'b0, 1'b1, 6'b101011, 32'd4, 32'h80FF_1234, 5'd0), 32'd0, 1'b0);
        run0(mk(1'b1, 1'b0, 6'b100000, 32'd4, 32'd0, 5'd3), 32'hFFFF_FF80, 1'b0);
        run0(mk(1'b1, 1'b0, 6'b100100, 32'd5, 32'd0, 5'd4), 32'h0000_00FF, 1'b0);
        run0(mk(1'b1, 1'b0, 6'b100001, 32'd6, 32'd0, 5'd5), 32'h0000_1234, 1'b0);
        run0(mk(1'b0, 1'b1, 6'b101000, 32'd7, 32'h0000_00AA, 5'd0), 32'd0, 1'b0);
        run0(mk(1'b1, 1'b0, 6'b100011, 32'd4, 32'd0, 5'd6), 32'h80FF_12AA, 1'b0);
        run0(mk(1'b1, 1'b0, 6'b100101, 32'd4, 32'd0, 5'd7), 32'h0000_80FF, 1'b0);
        run0(mk(1'b1, 1'b0, 6'b100001, 32'd4, 32'd0, 5'd8), 32'hFFFF_80FF, 1'b0);
        run0(mk(1'b1, 1'b0, 6'b100011, 32'd6, 32'd0, 5'd9), 32'd0, 1'b1);
        run0(mk(1'b0, 1'b1, 6'b101001, 32'd3, 32'd1, 5'd0), 32'd0, 1'b1);
        run0(mk(1'b1, 1'b0, 6'b100011, 32'd0, 32'd0, 5'd10), 32'd0, 1'b0);
        run0(mk(1'b0, 1'b0, 6'b001000, 32'd20, 32'd0, 5'd11), 32'd0, 1'b0);
        run0(mk(1'b0, 1'b1, 6'b101011, 32'h0000_0400, 32'd7, 5'd0), 32'd0, 1'b0);
        run0(mk(1'b1, 1'b0, 6'b100011, 32'd0, 32'd0, 5'd12), 32'd7, 1'b0);
        run0(mk(1'b1, 1'b1, 6'b111111, 32'd8, 32'h0BAD_F00D, 5'd13), 32'd50, 1'b0);
        run0(mk(1'b1, 1'b0, 6'b100011, 32'd8, 32'd0, 5'd14), 32'h0BAD_F00D, 1'b0);

        // Three wait states: stall length, hold, store-then-load forwarding.
        run3(mk(1'b1, 1'b0, 6'b100011, 32'd8, 32'd0, 5'd1), 32'd0, 3);
        run3(mk(1'b0, 1'b1, 6'b101011, 32'd16, 32'h0000_1234, 5'd0), 32'd0, 3);
        run3(mk(1'b1, 1'b0, 6'b100011, 32'd16, 32'd0, 5'd2), 32'h0000_1234, 3);
        run3(mk(1'b1, 1'b0, 6'b100011, 32'd18, 32'd0, 5'd3), 32'd0, 0);

        // Reset in the middle of a waiting store.
        @(negedge CLK);
        in3 = mk(1'b0, 1'b1, 6'b101011, 32'd20, 32'h0000_5555, 5'd0);
        @(posedge CLK);
        #1;
        chk_val("l3_sw_stalling", 32'(stall3), 32'd1);
        @(negedge CLK);
        rst3 = 1'b1;
        @(posedge CLK);
        #1;
        chk_zero3("l3_rst_stall");
        @(negedge CLK);
        rst3 = 1'b0;
        in3  = '0;
        run3(mk(1'b1, 1'b0, 6'b100011, 32'd20, 32'd0, 5'd4), 32'd0, 3);
        run3(mk(1'b1, 1'b0, 6'b100011, 32'd16, 32'd0, 5'd5), 32'd0, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
